ifetch_prefetch: RTL
====================

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_VECTOR, default 32'h00000000, first fetch address.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 imem_req_valid  output  1  fetch request present.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  in-order instruction return (no backpressure).
REQ-010 imem_rsp_data  input  XLEN  returned instruction.
REQ-011 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  input  XLEN  new fetch address.
REQ-013 stall  input  1  decode stall (hazard unit stallD); hold output.
REQ-014 out_valid  output  1  out_instr/out_pc_plus_4 valid for IF/ID.
REQ-015 out_instr  output  XLEN  instruction; NOP_INSTRUCTION when out_valid=0.
REQ-016 out_pc_plus_4  output  XLEN  instruction address + 4.

Function
REQ-017 SHALL issue imem_req_valid=1 iff (occupancy + outstanding) < DEPTH and no redirect this cycle.
REQ-018 SHALL hold imem_req_addr stable while imem_req_valid && !imem_req_ready, except on redirect.
REQ-019 SHALL increment fetch_pc by 4 and outstanding by 1 on each accepted request (valid&&ready).
REQ-020 SHALL push {rsp_data, addr+4} into the buffer on imem_rsp_valid when drop_cnt==0, decrementing outstanding.
REQ-021 SHALL present buffer head on outputs; head pops when out_valid && !stall.
REQ-022 SHALL give redirect priority over stall, request and response: next cycle buffer empty, fetch_pc=redirect_pc with bits [1:0] forced 0, drop_cnt=outstanding (+1 if a request is accepted in the redirect cycle), outstanding=0.
REQ-023 SHALL discard responses while drop_cnt>0, decrementing drop_cnt; a response coincident with redirect counts toward dropping.
REQ-024 SHALL keep imem_req_valid=0 in the redirect cycle; new-address request appears the following cycle.
REQ-025 SHALL never overflow: response with buffer full is impossible by REQ-017; simulation assertion flags it.
REQ-026 SHALL support simultaneous push and pop with occupancy unchanged; pointers wrap modulo DEPTH.
REQ-027 Latency: response accepted cycle N appears on outputs cycle N+1 (bypass disabled).

Reset
REQ-028 SHALL on rst: fetch_pc=RESET_VECTOR, occupancy/outstanding/drop_cnt=0, imem_req_valid=0, out_valid=0, out_instr=NOP_INSTRUCTION, out_pc_plus_4=0.
REQ-029 SHALL issue the first request (addr RESET_VECTOR) in the first cycle after rst deasserts; reset mid-operation discards all buffered and outstanding data, and responses after reset are ignored until a new request is accepted.

Configuration
REQ-030 Macro IFETCH_BYPASS_EN defined: response arriving with buffer empty, drop_cnt==0 and !stall SHALL drive outputs combinationally same cycle without being stored.
REQ-031 Macro IFETCH_BYPASS_EN undefined: SHALL use REQ-027 latency only; no combinational path imem_rsp_* -> out_*.

Structure
REQ-032 XLEN, NOP_INSTRUCTION and typedef fetch_entry_t {instr, pc_plus_4} SHALL live in the shared defs package.
REQ-033 Buffer SHALL be sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, full/empty/count).
REQ-034 Counters SHALL be $clog2(DEPTH)+1 bits wide.

Verification
REQ-035 Reset then ready=1, 1-cycle memory: requests 0x0,0x4,0x8..., out_pc_plus_4 sequence 0x4,0x8,0xC.
REQ-036 stall=1 for 10 cycles, ready=1: exactly DEPTH=4 requests outstanding/buffered, no further request, outputs frozen.
REQ-037 Two requests outstanding (3-cycle memory), redirect_pc=0x103: both old responses dropped, next request 0x100, first out_pc_plus_4=0x104.
REQ-038 ready=0 for 5 cycles: imem_req_addr held at 0x8; accepted once ready=1.
REQ-039 Redirect coincident with response and stall=1: response dropped, out_valid=0 next cycle.
REQ-040 rst asserted mid-stream with 2 outstanding: outputs NOP/0 immediately; restart at RESET_VECTOR; with IFETCH_BYPASS_EN, first instruction visible in response cycle.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: datapath width,
// the NOP presented when no instruction is available, and the buffer entry.
package ifetch_prefetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_prefetch_fifo.sv
// fetch_fifo: small circular buffer of fetched instructions.
// Flush has priority over push and pop; push and pop in the same cycle
// leave the occupancy unchanged. Pointers wrap modulo DEPTH (power of 2).
module fetch_fifo
    import ifetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    // a full buffer can still accept a push when the head leaves the same cycle
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // pointer and occupancy next state; flush discards everything
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction prefetcher feeding the IF/ID register.
// Issues word-aligned fetches ahead of decode, buffers in-order responses
// in fetch_fifo, and on a redirect flushes the buffer and discards the
// responses still in flight for the old path (drop_cnt).
//
// Build option: IFETCH_BYPASS_EN -- when defined, a response arriving with
// an empty buffer, nothing to drop and decode not stalled is forwarded to
// the outputs in the same cycle instead of being stored. When undefined,
// responses always pass through the buffer (one cycle latency) and there is
// no combinational path from imem_rsp_* to out_*.
module ifetch_prefetch #(
    parameter int                              XLEN         = ifetch_prefetch_pkg::XLEN,
    parameter int                              DEPTH        = 4,
    parameter logic [ifetch_prefetch_pkg::XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc_plus_4
);

    import ifetch_prefetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // next address to request, and address of the next response to keep
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    // requests accepted by memory whose response has not yet returned
    logic [CW-1:0]   outstanding_q, outstanding_d;
    // responses still to arrive that belong to a flushed path
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            fifo_push, fifo_pop;
    fetch_entry_t    fifo_head, fifo_wdata;

    logic [CW:0]     inflight;
    logic            req_fire;
    logic            rsp_keep, rsp_drop;
    logic            bypass_take;

    // Every kept response needs a buffer slot, so buffered plus in-flight
    // work is capped at DEPTH. The full term is redundant with that sum but
    // keeps the request gate obviously safe.
    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && !redirect_valid && !fifo_full && (inflight < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding (e.g. left over from before a
    // reset) is ignored. Old-path responses are consumed by drop_cnt first.
    assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && (outstanding_q != '0);
    assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass_take = rsp_keep && fifo_empty && !stall && !redirect_valid;
`else
    assign bypass_take = 1'b0;
`endif

    assign fifo_push  = rsp_keep && !redirect_valid && !bypass_take;
    assign fifo_pop   = !stall;
    assign fifo_wdata = '{instr: imem_rsp_data, pc_plus_4: rsp_pc_q + XLEN'(4)};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // address and counter next state; a redirect overrides everything else
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d    = align_word(redirect_pc);
            rsp_pc_d      = align_word(redirect_pc);
            outstanding_d = '0;
            // everything still in flight becomes garbage; a response landing
            // in this very cycle is one of those and is already accounted for
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(req_fire)
                            - CW'(rsp_keep || rsp_drop);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    // address and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // IF/ID outputs: buffer head, optional same-cycle forward, else NOP
    always_comb begin
        out_valid     = 1'b0;
        out_instr     = NOP_INSTRUCTION;
        out_pc_plus_4 = '0;
        if (!fifo_empty) begin
            out_valid     = 1'b1;
            out_instr     = fifo_head.instr;
            out_pc_plus_4 = fifo_head.pc_plus_4;
        end
`ifdef IFETCH_BYPASS_EN
        else if (bypass_take) begin
            out_valid     = 1'b1;
            out_instr     = imem_rsp_data;
            out_pc_plus_4 = rsp_pc_q + XLEN'(4);
        end
`endif
    end

    // a kept response always has a free slot because of the request gate
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule
